// File: rtl/s_axi_mem.sv
// AXI4 responder backed by an internal dual-port RAM of 2^MEM_AWIDTH bytes at BASE_ADDR.
// One write burst (AW/W/B) and one read burst (AR/R) are serviced at a time; the two
// directions run independently, so AW and AR may handshake in the same cycle.
//
// Ports
//   clk, xrst                      clock, synchronous active-high reset
//   aw*  (valid/ready/id/addr/len/size/burst, lock/cache/prot/qos/user ignored)
//   w*   (valid/ready/data/strb/last)
//   b*   (valid/ready/id/resp/user; buser driven 0)
//   ar*  (valid/ready/id/addr/len/size/burst, lock/cache/prot/qos/user ignored)
//   r*   (valid/ready/id/data/resp/last/user; ruser driven 0)
//
// Responses: out-of-range beat -> DECERR; non-INCR burst or oversize beat -> SLVERR with no
// RAM access; wlast in the wrong place -> SLVERR but data still written. B carries the worst
// response of the burst. Reads are read-first against a same-cycle write.
//
// Optional build macro MEM_RANDOM_STALL_EN: a 16-bit LFSR (seed 16'hACE1) inserts
// pseudo-random wready gaps and delays new R beats.
module s_axi_mem #(
  parameter int unsigned       DWIDTH      = 32,
  parameter int unsigned       ID_WIDTH    = 1,
  parameter int unsigned       BUSER_WIDTH = 1,
  parameter int unsigned       RUSER_WIDTH = 1,
  parameter int unsigned       MEM_AWIDTH  = 12,
  parameter logic [DWIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                   clk,
  input  logic                   xrst,
  // Write address
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [ID_WIDTH-1:0]    awid,
  input  logic [DWIDTH-1:0]      awaddr,
  input  logic [7:0]             awlen,
  input  logic [2:0]             awsize,
  input  logic [1:0]             awburst,
  input  logic                   awlock,
  input  logic [3:0]             awcache,
  input  logic [2:0]             awprot,
  input  logic [3:0]             awqos,
  input  logic                   awuser,
  // Write data
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [DWIDTH-1:0]      wdata,
  input  logic [DWIDTH/8-1:0]    wstrb,
  input  logic                   wlast,
  // Write response
  output logic                   bvalid,
  input  logic                   bready,
  output logic [ID_WIDTH-1:0]    bid,
  output logic [1:0]             bresp,
  output logic [BUSER_WIDTH-1:0] buser,
  // Read address
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [ID_WIDTH-1:0]    arid,
  input  logic [DWIDTH-1:0]      araddr,
  input  logic [7:0]             arlen,
  input  logic [2:0]             arsize,
  input  logic [1:0]             arburst,
  input  logic                   arlock,
  input  logic [3:0]             arcache,
  input  logic [2:0]             arprot,
  input  logic [3:0]             arqos,
  input  logic                   aruser,
  // Read data
  output logic                   rvalid,
  input  logic                   rready,
  output logic [ID_WIDTH-1:0]    rid,
  output logic [DWIDTH-1:0]      rdata,
  output logic [1:0]             rresp,
  output logic                   rlast,
  output logic [RUSER_WIDTH-1:0] ruser
);

  localparam int unsigned       NumBytes = DWIDTH / 8;
  localparam int unsigned       Lsb      = $clog2(NumBytes);
  localparam int unsigned       IdxW     = MEM_AWIDTH - Lsb;
  localparam int unsigned       Words    = 2 ** IdxW;
  localparam logic [2:0]        MaxSize  = 3'(Lsb);
  localparam logic [DWIDTH-1:0] One      = DWIDTH'(1);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;
  localparam logic [1:0] BurstIncr  = 2'b01;

  logic unused_sigs;
  assign unused_sigs = ^{awlock, awcache, awprot, awqos, awuser,
                         arlock, arcache, arprot, arqos, aruser};

  function automatic logic in_range(input logic [DWIDTH-1:0] a);
    return a[DWIDTH-1:MEM_AWIDTH] == BASE_ADDR[DWIDTH-1:MEM_AWIDTH];
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [DWIDTH-1:0] a);
    return a[MEM_AWIDTH-1:Lsb];
  endfunction

  // ---------------------------------------------------------------------------------------
  // Stall source
  // ---------------------------------------------------------------------------------------
  logic stall;

`ifdef MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Right-shifting form of x^16 + x^14 + x^13 + x^11 + 1.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign stall   = lfsr_q[0];

  always_ff @(posedge clk) begin
    if (xrst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end
`else
  assign stall = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------------------
  logic [DWIDTH-1:0] mem_q [Words];

  // ---------------------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------------------
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  w_state_e            w_state_q, w_state_d;
  logic                awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0] bid_q;
  logic [1:0]          bresp_q;
  logic [DWIDTH-1:0]   w_addr_q;
  logic [7:0]          w_len_q, w_cnt_q;
  logic [2:0]          w_size_q;
  logic                w_err_q;

  logic       aw_hs, w_hs, b_hs, w_last_beat, w_oor, w_we;
  logic [1:0] w_beat_resp;

  assign aw_hs       = awvalid & awready_q;
  assign wready      = wready_q & ~stall;
  assign w_hs        = wvalid & wready;
  assign b_hs        = bvalid_q & bready;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_oor       = ~in_range(w_addr_q);
  // A beat caught by reset is dropped along with the rest of the burst.
  assign w_we        = w_hs & ~w_oor & ~w_err_q & ~xrst;

  always_comb begin
    w_beat_resp = RespOkay;
    if (w_oor) begin
      w_beat_resp = RespDecerr;
    end else if (w_err_q || (wlast != w_last_beat)) begin
      w_beat_resp = RespSlverr;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (aw_hs) w_state_d = WData;
      WData:   if (w_hs && w_last_beat) w_state_d = WResp;
      WResp:   if (b_hs) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      w_state_q <= WIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RespOkay;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      // Handshake flags follow the state being entered so they change on the same edge.
      awready_q <= (w_state_d == WIdle);
      wready_q  <= (w_state_d == WData);
      bvalid_q  <= (w_state_d == WResp);
      if (aw_hs) begin
        bid_q    <= awid;
        bresp_q  <= RespOkay;
        w_addr_q <= awaddr;
        w_len_q  <= awlen;
        w_cnt_q  <= '0;
        w_size_q <= awsize;
        w_err_q  <= (awburst != BurstIncr) || (awsize > MaxSize);
      end else if (w_hs) begin
        w_addr_q <= w_addr_q + (One << w_size_q);
        w_cnt_q  <= w_cnt_q + 8'd1;
        // Codes are ordered so the numerically larger one is the more severe.
        if (w_beat_resp > bresp_q) bresp_q <= w_beat_resp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (wstrb[i]) mem_q[word_idx(w_addr_q)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign awready = awready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign buser   = '0;

  // ---------------------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------------------
  typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_e;

  r_state_e            r_state_q, r_state_d;
  logic                arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0] rid_q;
  logic [DWIDTH-1:0]   rdata_q;
  logic [1:0]          rresp_q;
  logic [DWIDTH-1:0]   r_addr_q;
  logic [7:0]          r_len_q;
  logic [8:0]          r_cnt_q;  // index of the next beat to load into the output register
  logic [2:0]          r_size_q;
  logic                r_err_q;

  logic ar_hs, r_hs, r_pending, r_load, r_oor;

  assign ar_hs     = arvalid & arready_q;
  assign r_hs      = rvalid_q & rready;
  assign r_pending = (r_cnt_q <= {1'b0, r_len_q});
  // The output register refills when empty or being drained this cycle, so beats stream
  // back-to-back and held data stays put while the master stalls.
  assign r_load    = (r_state_q != RIdle) & r_pending & (~rvalid_q | rready) & ~stall;
  assign r_oor     = ~in_range(r_addr_q);

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_hs) r_state_d = RFetch;
      RFetch:  if (r_load) r_state_d = RData;
      RData:   if (r_hs && rlast_q) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      r_state_q <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_err_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == RIdle);
      if (ar_hs) begin
        rid_q    <= arid;
        r_addr_q <= araddr;
        r_len_q  <= arlen;
        r_cnt_q  <= '0;
        r_size_q <= arsize;
        r_err_q  <= (arburst != BurstIncr) || (arsize > MaxSize);
      end
      if (r_load) begin
        rvalid_q <= 1'b1;
        rlast_q  <= (r_cnt_q[7:0] == r_len_q);
        r_addr_q <= r_addr_q + (One << r_size_q);
        r_cnt_q  <= r_cnt_q + 9'd1;
        if (r_oor) begin
          rresp_q <= RespDecerr;
          rdata_q <= '0;
        end else if (r_err_q) begin
          rresp_q <= RespSlverr;
          rdata_q <= '0;
        end else begin
          rresp_q <= RespOkay;
          rdata_q <= mem_q[word_idx(r_addr_q)];
        end
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign ruser   = '0;

endmodule

// File: tb/tb_s_axi_mem.sv
// Self-checking bench for s_axi_mem: a byte-accurate memory model predicts B and R
// responses, which are queued at stimulus time and compared as the DUT produces them.
module tb_s_axi_mem;

  localparam int IW  = 1;
  localparam int Tmo = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          xrst;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [31:0]   awaddr, araddr, wdata, rdata;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [3:0]    wstrb;
  logic          wlast, arvalid, arready, rvalid, rready, rlast;
  logic [0:0]    buser, ruser;

  s_axi_mem dut (
    .clk(clk), .xrst(xrst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(1'b0), .awcache(4'h0), .awprot(3'h0),
    .awqos(4'h0), .awuser(1'b0),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .buser(buser),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(1'b0), .arcache(4'h0), .arprot(3'h0),
    .arqos(4'h0), .aruser(1'b0),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .ruser(ruser)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [IW-1:0] id;
    logic [31:0]   data;
    logic [1:0]    resp;
    logic          last;
  } r_exp_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  r_exp_t      r_q[$];
  b_exp_t      b_q[$];
  logic [31:0] model [1024];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) model[a[11:2]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic wr_burst(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [31:0] dbase, input logic [3:0] strb,
                          input int early, input int bdelay);
    logic [31:0] a;
    logic [1:0]  acc, r;
    logic        err, oor, wl;
    int          g;
    logic        w_ok;
    b_exp_t      e;
    a   = addr;
    acc = 2'b00;
    err = (burst != 2'b01) || (size > 3'd2);
    for (int i = 0; i <= len; i++) begin
      oor = (a[31:12] != 20'h0);
      wl  = (i == len) || (i == early);
      r   = oor ? 2'b11 : ((err || (wl != (i == len))) ? 2'b10 : 2'b00);
      if (!oor && !err) mem_wr(a, dbase + 32'(i), strb);
      if (r > acc) acc = r;
      a = a + (32'd1 << size);
    end
    e.id   = id;
    e.resp = acc;
    b_q.push_back(e);

    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
    awvalid = 1'b1;
    g = 0;
    while (!awready && g < Tmo) begin tick(); g++; end
    check("aw_wait", 64'(g < Tmo), 1);
    tick();
    awvalid = 1'b0;

    w_ok = 1'b1;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1;
      wdata  = dbase + 32'(i);
      wstrb  = strb;
      wlast  = (i == len) || (i == early);
      g = 0;
      while (!wready && g < Tmo) begin tick(); g++; end
      if (g >= Tmo) w_ok = 1'b0;
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    check("w_wait", 64'(w_ok), 1);

    g = 0;
    while (!bvalid && g < Tmo) begin tick(); g++; end
    check("b_wait", 64'(g < Tmo), 1);
    e = b_q.pop_front();
    for (int k = 0; k < bdelay; k++) begin
      check("b_hold_valid", 64'(bvalid), 1);
      check("b_hold_resp", 64'(bresp), 64'(e.resp));
      check("b_hold_awready", 64'(awready), 0);
      tick();
    end
    bready = 1'b1;
    check("bid", 64'(bid), 64'(e.id));
    check("bresp", 64'(bresp), 64'(e.resp));
    tick();
    bready = 1'b0;
    check("b_drop", 64'(bvalid), 0);
    check("aw_rearm", 64'(awready), 1);
  endtask

  // mode 0: rready held 1; mode 1: rready toggles 1,0,1,0 each cycle
  task automatic rd_burst(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode);
    logic [31:0] a;
    logic        err, oor;
    r_exp_t      e;
    int          g, got, cyc, first_c, last_c;
    a   = addr;
    err = (burst != 2'b01) || (size > 3'd2);
    for (int i = 0; i <= len; i++) begin
      oor    = (a[31:12] != 20'h0);
      e.id   = id;
      e.resp = oor ? 2'b11 : (err ? 2'b10 : 2'b00);
      e.data = (e.resp == 2'b00) ? model[a[11:2]] : 32'h0;
      e.last = (i == len);
      r_q.push_back(e);
      a = a + (32'd1 << size);
    end

    rready = 1'b0;
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
    arvalid = 1'b1;
    g = 0;
    while (!arready && g < Tmo) begin tick(); g++; end
    check("ar_wait", 64'(g < Tmo), 1);
    tick();
    arvalid = 1'b0;
`ifndef MEM_RANDOM_STALL_EN
    check("r_lat_c1", 64'(rvalid), 0);
    tick();
    check("r_lat_c2", 64'(rvalid), 1);
`endif

    got = 0; cyc = 0; first_c = 0; last_c = 0;
    while (got <= len && cyc < Tmo) begin
      rready = (mode == 0) || (cyc % 2 == 0);
      if (rvalid) begin
        e = r_q[0];
        if (rready) begin
          void'(r_q.pop_front());
          check("rdata", 64'(rdata), 64'(e.data));
          check("rresp", 64'(rresp), 64'(e.resp));
          check("rlast", 64'(rlast), 64'(e.last));
          check("rid", 64'(rid), 64'(e.id));
          if (got == 0) first_c = cyc;
          last_c = cyc;
          got++;
        end else begin
          check("r_stall_data", 64'(rdata), 64'(e.data));
          check("r_stall_resp", 64'(rresp), 64'(e.resp));
          check("r_stall_last", 64'(rlast), 64'(e.last));
        end
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    check("r_beats", 64'(got), 64'(len + 1));
    check("r_drop", 64'(rvalid), 0);
    check("ar_rearm", 64'(arready), 1);
`ifndef MEM_RANDOM_STALL_EN
    if (mode == 0) check("r_b2b", 64'(last_c - first_c), 64'(len));
`endif
    r_q.delete();
  endtask

  task automatic t1();
    wr_burst(1'b1, 32'h000, 255, 3'd2, 2'b01, 32'h0, 4'hF, -1, 0);
    rd_burst(1'b0, 32'h000, 255, 3'd2, 2'b01, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int     g;
    logic   seen_b;
    xrst = 1'b1;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    repeat (3) tick();

    // Reset values
    check("rst_awready", 64'(awready), 0);
    check("rst_arready", 64'(arready), 0);
    check("rst_wready", 64'(wready), 0);
    check("rst_bvalid", 64'(bvalid), 0);
    check("rst_rvalid", 64'(rvalid), 0);
    check("rst_rlast", 64'(rlast), 0);
    check("rst_bresp", 64'(bresp), 0);
    check("rst_rresp", 64'(rresp), 0);
    check("rst_rdata", 64'(rdata), 0);
    check("rst_bid", 64'(bid), 0);
    check("rst_rid", 64'(rid), 0);
    xrst = 1'b0;
    tick();
    check("post_rst_awready", 64'(awready), 1);
    check("post_rst_arready", 64'(arready), 1);

    // T1: 256-beat write then read
    t1();

    // T2: byte strobes
    wr_burst(1'b0, 32'h010, 0, 3'd2, 2'b01, 32'h11223344, 4'hF, -1, 0);
    wr_burst(1'b0, 32'h010, 0, 3'd2, 2'b01, 32'hAABBCCDD, 4'h3, -1, 0);
    check("t2_model", 64'(model[4]), 64'h1122CCDD);
    rd_burst(1'b1, 32'h010, 0, 3'd2, 2'b01, 0);

    // T3: range and protocol errors
    wr_burst(1'b1, 32'hFF8, 3, 3'd2, 2'b01, 32'hC0DE0000, 4'hF, -1, 0);
    rd_burst(1'b0, 32'hFF8, 3, 3'd2, 2'b01, 0);
    wr_burst(1'b0, 32'h020, 0, 3'd2, 2'b00, 32'hDEADBEEF, 4'hF, -1, 0);
    rd_burst(1'b0, 32'h020, 0, 3'd2, 2'b01, 0);
    wr_burst(1'b0, 32'h024, 0, 3'd3, 2'b01, 32'hFEEDF00D, 4'hF, -1, 0);
    rd_burst(1'b0, 32'h024, 0, 3'd2, 2'b01, 0);
    wr_burst(1'b1, 32'h040, 1, 3'd2, 2'b01, 32'h0BAD0000, 4'hF, 0, 0);
    rd_burst(1'b1, 32'h040, 1, 3'd2, 2'b01, 0);
    rd_burst(1'b0, 32'h000, 1, 3'd2, 2'b10, 0);

    // T4: held-off write response
    wr_burst(1'b1, 32'h080, 0, 3'd2, 2'b01, 32'h44332211, 4'hF, -1, 10);

    // T5: read with rready toggling
    rd_burst(1'b1, 32'h100, 15, 3'd2, 2'b01, 1);

    // T6: reset in the middle of a write burst
    awid = 0; awaddr = 32'h800; awlen = 8'd9; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    g = 0;
    while (!awready && g < Tmo) begin tick(); g++; end
    check("t6_aw_wait", 64'(g < Tmo), 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wvalid = 1'b1; wdata = 32'h5000 + 32'(i); wstrb = 4'hF; wlast = 1'b0;
      g = 0;
      while (!wready && g < Tmo) begin tick(); g++; end
      mem_wr(32'h800 + 32'(4 * i), 32'h5000 + 32'(i), 4'hF);
      tick();
    end
    wdata = 32'h5005;
    xrst  = 1'b1;
    tick();
    check("t6_awready", 64'(awready), 0);
    check("t6_wready", 64'(wready), 0);
    check("t6_bvalid", 64'(bvalid), 0);
    check("t6_arready", 64'(arready), 0);
    check("t6_rvalid", 64'(rvalid), 0);
    wvalid = 1'b0;
    tick();
    xrst = 1'b0;
    seen_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bvalid) seen_b = 1'b1;
    end
    check("t6_no_b", 64'(seen_b), 0);
    check("t6_awready_back", 64'(awready), 1);
    rd_burst(1'b0, 32'h800, 4, 3'd2, 2'b01, 0);
    t1();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
